// File: rtl/gray_ptr_rx_pkg.sv
// gray_ptr_rx_pkg
// Shared constants and helpers for the Gray-pointer receive path.
// Holds the default word width, the legal width and synchroniser-depth
// bounds, and the Gray-to-binary and popcount functions. Both functions
// work on a 16-bit word (the widest legal pointer); narrower callers
// zero-extend their operand first, which leaves the upper result bits zero.
package gray_ptr_rx_pkg;

  localparam int GRAY_DEFAULT_WIDTH  = 4;
  localparam int GRAY_MIN_WIDTH      = 2;
  localparam int GRAY_MAX_WIDTH      = 16;

  localparam int SYNC_DEFAULT_STAGES = 2;
  localparam int SYNC_MIN_STAGES     = 2;
  localparam int SYNC_MAX_STAGES     = 4;

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [15:0] gray_to_bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_ptr_rx_sync.sv
// gray_sync
// Multi-flop synchroniser for a Gray-coded word arriving from another
// clock domain. Only the last stage may be consumed by downstream logic.
// Ports:
//   clk    - receive clock, rising edge
//   resetn - asynchronous active-low reset, clears every stage
//   d      - Gray word, possibly asynchronous to clk
//   q      - synchronised Gray word (last stage)
module gray_sync
  import gray_ptr_rx_pkg::*;
#(
  parameter int WIDTH  = GRAY_DEFAULT_WIDTH,
  parameter int STAGES = SYNC_DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("gray_sync: STAGES out of legal range");
  end

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the incoming word through the chain; reset clears every stage so
  // the output starts at the legal Gray code zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx
// Receives a Gray-coded pointer from an upstream Gray counter, synchronises
// it, decodes it to binary and classifies each change as a legal forward
// step (advance pulse, counted) or an illegal transition (sticky err).
// Ports:
//   clk     - receive clock, rising edge
//   resetn  - asynchronous active-low reset
//   gray_in - Gray-coded count, may be asynchronous to clk
//   clr_err - synchronous clear of err (a fault in the same cycle wins)
//   bin_out - registered binary decode of the synchronised value
//   advance - one-cycle pulse when bin_out steps forward by exactly one
//   err     - sticky illegal-transition flag
//   adv_cnt - saturating count of advance pulses
module gray_ptr_rx
  import gray_ptr_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = GRAY_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = SYNC_DEFAULT_STAGES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  advance,
  output logic                  err,
  output logic [7:0]            adv_cnt
);

  if (DATA_WIDTH < GRAY_MIN_WIDTH || DATA_WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
    $error("gray_ptr_rx: DATA_WIDTH out of legal range");
  end

  localparam logic [DATA_WIDTH-1:0] STEP_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] sync_last;
  logic [DATA_WIDTH-1:0] prev_gray_q;
  logic [15:0]           last_wide;
  logic [15:0]           flip_wide;
  logic [15:0]           dec_wide_unused_hi;
  logic [DATA_WIDTH-1:0] decoded_bin;
  logic [DATA_WIDTH-1:0] step;
  logic [4:0]            flips;
  logic                  step_one;
  logic                  set_err;

  gray_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (gray_in),
    .q      (sync_last)
  );

  // Widen to the package helper width; only the low DATA_WIDTH bits of the
  // decode carry information, the upper bits are always zero.
  always_comb begin
    last_wide = '0;
    flip_wide = '0;
    last_wide[DATA_WIDTH-1:0] = sync_last;
    flip_wide[DATA_WIDTH-1:0] = sync_last ^ prev_gray_q;
    dec_wide_unused_hi = gray_to_bin(last_wide);
    decoded_bin = dec_wide_unused_hi[DATA_WIDTH-1:0];
    flips = popcount16(flip_wide);
  end

  // Modular distance from the current output; wrap from all-ones to zero
  // naturally yields one. Anything other than zero or one is a fault, as is
  // a change touching more than one Gray bit.
  always_comb begin
    step     = decoded_bin - bin_out;
    step_one = (step == STEP_ONE);
    set_err  = ((step != '0) && !step_one) || (flips > 5'd1);
  end

  // Decode, pulse and error registers; a fault in the same cycle as clr_err
  // keeps err set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_gray_q <= '0;
      bin_out     <= '0;
      advance     <= 1'b0;
      err         <= 1'b0;
    end else begin
      prev_gray_q <= sync_last;
      bin_out     <= decoded_bin;
      advance     <= step_one;
      err         <= set_err | (err & ~clr_err);
    end
  end

  // Advance counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adv_cnt <= 8'd0;
    end else if (step_one && (adv_cnt != 8'hFF)) begin
      adv_cnt <= adv_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb_gray_ptr_rx
// Directed scoreboard bench for gray_ptr_rx (DATA_WIDTH=4, SYNC_STAGES=2).
// Each applied Gray word pushes its expected outputs tagged with the cycle
// at which they must appear (three edges later); a monitor pops and compares
// on every falling edge.
module tb_gray_ptr_rx;

  typedef struct {
    int         cyc;
    logic [3:0] bin;
    logic       adv;
    logic       err;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       advance;
  logic       err;
  logic [7:0] adv_cnt;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   clr_plan [0:2047];

  gray_ptr_rx #(
    .DATA_WIDTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .gray_in (gray_in),
    .clr_err (clr_err),
    .bin_out (bin_out),
    .advance (advance),
    .err     (err),
    .adv_cnt (adv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // clr_err is scheduled so that it is sampled on the same edge at which the
  // vector it belongs to reaches bin_out.
  always @(posedge clk) begin
    #1;
    clr_err = (cyc < 2048) ? clr_plan[cyc] : 1'b0;
  end

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if (bin_out !== e.bin || advance !== e.adv || err !== e.err || adv_cnt !== e.cnt) begin
      n_bad++;
      $display("[TB] FAIL %s @cyc %0d: got bin=%h adv=%b err=%b cnt=%0d, expected bin=%h adv=%b err=%b cnt=%0d",
               e.name, cyc, bin_out, advance, err, adv_cnt, e.bin, e.adv, e.err, e.cnt);
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  task automatic pushNow(input string nm);
    exp_t e;
    e.cyc = cyc; e.bin = 4'h0; e.adv = 1'b0; e.err = 1'b0; e.cnt = 8'd0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] g, input logic clr,
                               input logic [3:0] eb, input logic ea, input logic ee,
                               input logic [7:0] ec, input string nm);
    exp_t e;
    gray_in = g;
    if (clr && cyc + 2 < 2048) clr_plan[cyc + 2] = 1'b1;
    e.cyc = cyc + 3; e.bin = eb; e.adv = ea; e.err = ee; e.cnt = ec; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("[TB] FAIL drain: %0d expectations still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int cnt;
    int b;
    resetn  = 1'b0;
    gray_in = 4'h0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pushNow("reset_state");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, "post_reset_idle");

    // Full Gray cycle 1,3,2,...,8 then wrap to 0.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(to_gray(i), 1'b0, 4'(i & 15), 1'b1, 1'b0, 8'(i), "count16");
    end
    applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd16, "count_hold");

    applyStimulus(4'b0001, 1'b0, 4'd1, 1'b1, 1'b0, 8'd17, "to_0010_a");
    applyStimulus(4'b0011, 1'b0, 4'd2, 1'b1, 1'b0, 8'd18, "to_0010_b");
    applyStimulus(4'b0010, 1'b0, 4'd3, 1'b1, 1'b0, 8'd19, "to_0010_c");
    applyStimulus(4'b0111, 1'b0, 4'b0101, 1'b0, 1'b1, 8'd19, "two_bit_jump");
    applyStimulus(4'b0111, 1'b0, 4'b0101, 1'b0, 1'b1, 8'd19, "err_sticky");
    applyStimulus(4'b0111, 1'b1, 4'b0101, 1'b0, 1'b0, 8'd19, "clr_no_fault");
    applyStimulus(4'b0111, 1'b0, 4'b0101, 1'b0, 1'b0, 8'd19, "clr_hold");
    applyStimulus(4'b0011, 1'b1, 4'd2, 1'b0, 1'b1, 8'd19, "clr_with_fault");
    applyStimulus(4'b0011, 1'b1, 4'd2, 1'b0, 1'b0, 8'd19, "clr_after_fault");
    applyStimulus(4'b0001, 1'b0, 4'd1, 1'b0, 1'b1, 8'd19, "backward_step");
    applyStimulus(4'b0001, 1'b0, 4'd1, 1'b0, 1'b1, 8'd19, "backward_hold");
    applyStimulus(4'b0001, 1'b1, 4'd1, 1'b0, 1'b0, 8'd19, "clr_before_sat");

    // 300 forward steps from bin 1: counter climbs to 255 and holds.
    cnt = 19;
    for (int k = 1; k <= 300; k++) begin
      b = (1 + k) & 15;
      cnt = (cnt < 255) ? cnt + 1 : 255;
      applyStimulus(to_gray(b), 1'b0, 4'(b), 1'b1, 1'b0, 8'(cnt), "sat_step");
    end
    applyStimulus(to_gray(13), 1'b0, 4'd13, 1'b0, 1'b0, 8'd255, "sat_hold");

    // Walk forward to bin 9 for the mid-operation reset.
    for (int k = 14; k <= 25; k++) begin
      applyStimulus(to_gray(k & 15), 1'b0, 4'(k & 15), 1'b1, 1'b0, 8'd255, "to_nine");
    end
    applyStimulus(to_gray(9), 1'b0, 4'd9, 1'b0, 1'b0, 8'd255, "nine_hold");
    waitDrain();

    resetn  = 1'b0;
    gray_in = 4'h0;
    pushNow("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) applyStimulus(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, "post_mid_reset");
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
